// File: rtl/bit_field_pack.sv
// Streaming narrower/packer: narrows SIZE_IN-bit results to SIZE_OUT-bit fields and packs two per output word.
// Optional saturation and sticky overflow flag are enabled by defining BFP_SATURATE_EN; default build truncates.
module bit_field_pack #(
  parameter int SIZE_IN  = 32,
  parameter int SIZE_OUT = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SIZE_IN-1:0]      in_data,
  input  logic                    in_last,
  input  logic                    sat_signed,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*SIZE_OUT-1:0]   out_data,
  output logic [1:0]              out_mask,
  output logic                    ovf,
  input  logic                    ovf_clr
);

  logic                  accept;
  logic [SIZE_OUT-1:0]   narrow;
  logic                  clip;

  logic [SIZE_OUT-1:0]   hold_q, hold_d;
  logic                  hold_vld_q, hold_vld_d;
  logic [2*SIZE_OUT-1:0] out_data_q, out_data_d;
  logic [1:0]            out_mask_q, out_mask_d;
  logic                  out_valid_q, out_valid_d;

  // A new word may enter only when the output register is free or draining this cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

`ifdef BFP_SATURATE_EN
  always_comb begin
    narrow = in_data[SIZE_OUT-1:0];
    clip   = 1'b0;
    if (sat_signed) begin
      // Fits iff every bit from the field's sign bit upward matches the input sign.
      if (in_data[SIZE_IN-1:SIZE_OUT-1] != {(SIZE_IN-SIZE_OUT+1){in_data[SIZE_IN-1]}}) begin
        clip   = 1'b1;
        narrow = {in_data[SIZE_IN-1], {(SIZE_OUT-1){~in_data[SIZE_IN-1]}}};
      end
    end else if (|in_data[SIZE_IN-1:SIZE_OUT]) begin
      clip   = 1'b1;
      narrow = '1;
    end
  end

  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr)
      ovf_d = 1'b0;
    if (accept && clip)
      ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf_q <= 1'b0;
    else
      ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign narrow = in_data[SIZE_OUT-1:0];
  assign clip   = 1'b0;
  assign ovf    = 1'b0;

  logic unused_trunc;
  assign unused_trunc = ^{in_data[SIZE_IN-1:SIZE_OUT], sat_signed, ovf_clr, clip};
`endif

  always_comb begin
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    out_data_d  = out_data_q;
    out_mask_d  = out_mask_q;
    out_valid_d = out_valid_q;

    if (out_valid_q && out_ready)
      out_valid_d = 1'b0;

    // A load in the same cycle as a drain overrides the drop, keeping out_valid continuous.
    if (accept) begin
      if (hold_vld_q) begin
        out_data_d  = {narrow, hold_q};
        out_mask_d  = 2'b11;
        out_valid_d = 1'b1;
        hold_vld_d  = 1'b0;
      end else if (in_last) begin
        out_data_d  = {{SIZE_OUT{1'b0}}, narrow};
        out_mask_d  = 2'b01;
        out_valid_d = 1'b1;
      end else begin
        hold_d      = narrow;
        hold_vld_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      out_data_q  <= '0;
      out_mask_q  <= 2'b00;
      out_valid_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      out_data_q  <= out_data_d;
      out_mask_q  <= out_mask_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_mask  = out_mask_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_bit_field_pack.sv
// Directed, table-driven bench for bit_field_pack; covers pairing, flush, backpressure, reset and narrowing modes.
module tb_bit_field_pack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        sat_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_mask;
  logic        ovf;
  logic        ovf_clr;

  int checks = 0;
  int errors = 0;

  bit_field_pack #(.SIZE_IN(32), .SIZE_OUT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .sat_signed (sat_signed),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_mask   (out_mask),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [1:0]  exp_mask;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{32'h0000_1234, 1'b0, 1'b0, 32'h0000_0000, 2'b00};
    vecs[1] = '{32'h0000_ABCD, 1'b0, 1'b1, 32'hABCD_1234, 2'b11};
    vecs[2] = '{32'h0000_0077, 1'b1, 1'b1, 32'h0000_0077, 2'b01};
    vecs[3] = '{32'h0000_0011, 1'b0, 1'b0, 32'h0000_0000, 2'b00};
    vecs[4] = '{32'h0000_0022, 1'b1, 1'b1, 32'h0022_0011, 2'b11};
    vecs[5] = '{32'h0001_2345, 1'b0, 1'b0, 32'h0000_0000, 2'b00};
`ifdef BFP_SATURATE_EN
    vecs[6] = '{32'hFFFE_0000, 1'b0, 1'b1, 32'h8000_7FFF, 2'b11};
`else
    vecs[6] = '{32'hFFFE_0000, 1'b0, 1'b1, 32'h0000_2345, 2'b11};
`endif
    vecs[7] = '{32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_FFFF, 2'b01};
    vecs[8] = '{32'hFFFF_8000, 1'b0, 1'b0, 32'h0000_0000, 2'b00};
`ifdef BFP_SATURATE_EN
    vecs[9] = '{32'h0000_8000, 1'b0, 1'b1, 32'h7FFF_8000, 2'b11};
`else
    vecs[9] = '{32'h0000_8000, 1'b0, 1'b1, 32'h8000_8000, 2'b11};
`endif

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_last    = 1'b0;
    sat_signed = 1'b1;
    out_ready  = 1'b1;
    ovf_clr    = 1'b0;

    #2;
    check("reset out_valid", {31'b0, out_valid}, 32'd0);
    check("reset out_data", out_data, 32'd0);
    check("reset out_mask", {30'b0, out_mask}, 32'd0);
    check("reset ovf", {31'b0, ovf}, 32'd0);
    #10 rst_n = 1'b1;
    cyc();
    check("post-reset in_ready", {31'b0, in_ready}, 32'd1);

    // One input per cycle with the consumer always ready.
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = vecs[i].data;
      in_last  = vecs[i].last;
      cyc();
      check($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d out_data", i), out_data, vecs[i].exp_data);
        check($sformatf("vec%0d out_mask", i), {30'b0, out_mask}, {30'b0, vecs[i].exp_mask});
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;

`ifdef BFP_SATURATE_EN
    check("table ovf sticky", {31'b0, ovf}, 32'd1);
`else
    check("table ovf", {31'b0, ovf}, 32'd0);
`endif

    // Clear, then clear and overflow together (set wins when saturating).
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    check("ovf after clear", {31'b0, ovf}, 32'd0);
    check("drained out_valid", {31'b0, out_valid}, 32'd0);

    in_valid   = 1'b1;
    in_data    = 32'h0001_0000;
    in_last    = 1'b1;
    sat_signed = 1'b0;
    ovf_clr    = 1'b1;
    cyc();
    in_valid = 1'b0;
    in_last  = 1'b0;
    ovf_clr  = 1'b0;
`ifdef BFP_SATURATE_EN
    check("clr+ovf same cycle", {31'b0, ovf}, 32'd1);
    check("unsigned clip data", out_data, 32'h0000_FFFF);
`else
    check("trunc ovf tied", {31'b0, ovf}, 32'd0);
    check("unsigned trunc data", out_data, 32'h0000_0000);
`endif
    check("unsigned flush mask", {30'b0, out_mask}, 32'd1);
    cyc();
    sat_signed = 1'b1;

    // Backpressure: output stalls, input blocked, data stable; release with a flush word gives no bubble.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h0000_0001;
    cyc();
    in_data   = 32'h0000_0002;
    cyc();
    in_data   = 32'h0000_0003;
    in_last   = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall%0d in_ready", k), {31'b0, in_ready}, 32'd0);
      check($sformatf("stall%0d out_data", k), out_data, 32'h0002_0001);
      cyc();
    end
    check("stall out_mask", {30'b0, out_mask}, 32'd3);
    out_ready = 1'b1;
    #1;
    check("release in_ready", {31'b0, in_ready}, 32'd1);
    cyc();
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("no-bubble out_valid", {31'b0, out_valid}, 32'd1);
    check("no-bubble out_data", out_data, 32'h0000_0003);
    check("no-bubble out_mask", {30'b0, out_mask}, 32'd1);
    cyc();
    check("drain out_valid", {31'b0, out_valid}, 32'd0);

    // Reset mid-pair must discard the held half-word.
    in_valid = 1'b1;
    in_data  = 32'h0000_0005;
    cyc();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midreset out_valid", {31'b0, out_valid}, 32'd0);
    check("midreset out_mask", {30'b0, out_mask}, 32'd0);
    check("midreset ovf", {31'b0, ovf}, 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h0000_0001;
    cyc();
    in_data  = 32'h0000_0002;
    cyc();
    in_valid = 1'b0;
    check("after reset out_valid", {31'b0, out_valid}, 32'd1);
    check("after reset out_data", out_data, 32'h0002_0001);
    check("after reset out_mask", {30'b0, out_mask}, 32'd3);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
